// File: rtl/hs_pkg.sv
// Shared types and default parameters for the send/ack 4-phase handshake sender.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/hs_fifo.sv
// Synchronous FIFO with async reset; the head word is readable without popping.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Guarded internally so a stray push when full or pop when empty is harmless.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/hs_sender.sv
// Upstream master of the send/ack 4-phase handshake: buffers producer words and
// delivers each one as a full send/ack cycle, with an optional ack timeout.
module hs_sender
  import hs_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   send,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             o_state
);

  // Producer side: a word moves when in_valid && in_ready at a rising edge;
  // the producer holds in_data/in_valid until that happens.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t           r_state;
  logic             r_send;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic             r_err;
  logic [TW-1:0]    r_tmo;

  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_timeout;
  logic             w_pop;

  assign w_timeout = (TIMEOUT != 0) && (r_tmo == TW'(TIMEOUT - 1));
  // The word leaves the FIFO exactly on the REQ->REL transition (ack or timeout).
  assign w_pop     = (r_state == REQ) && (ack || w_timeout);

  hs_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid && !w_full),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // A stale ack from the peripheral must clear before a new request.
          if (!w_empty && !ack) begin
            r_state <= REQ;
            r_send  <= 1'b1;
            r_data  <= w_head;
            r_tmo   <= '0;
          end
        end
        REQ: begin
          if (ack) begin
            r_done  <= 1'b1;
            r_send  <= 1'b0;
            r_state <= REL;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_send  <= 1'b0;
            r_state <= REL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        REL: begin
          if (!ack) begin
            if (!w_empty) begin
              r_state <= REQ;
              r_send  <= 1'b1;
              r_data  <= w_head;
              r_tmo   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = !w_full;
  assign send     = r_send;
  assign data_out = r_data;
  assign done     = r_done;
  assign err      = r_err;
  assign o_state  = r_state;

endmodule

// File: tb/tb_hs_sender.sv
// Bench for hs_sender: producer driver, negedge peripheral model, scoreboard on send rises.
module tb_hs_sender;
  import hs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       send;
  logic [7:0] data_out;
  logic       ack;
  logic [2:0] count;
  logic       done;
  logic       err;
  logic [1:0] o_state;

  logic       ack_mode;
  logic       m_ack;
  int         hi_cnt, lo_cnt;

  logic [7:0] exp_q[$];
  int         rise_t[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_done = 0, n_err = 0, n_send_hi = 0, n_over = 0, n_unstable = 0, cyc = 0;
  logic       p_send;
  logic [7:0] p_data;

  hs_sender #(.WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .send     (send),
    .data_out (data_out),
    .ack      (ack),
    .count    (count),
    .done     (done),
    .err      (err),
    .o_state  (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // peripheral: ack rises 2 cycles after sampling send, falls 1 cycle after sampling it low
  assign ack = ack_mode & m_ack;
  initial begin
    m_ack = 1'b0; hi_cnt = 0; lo_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ack = 1'b0; hi_cnt = 0; lo_cnt = 0;
      end else if (send) begin
        lo_cnt = 0; hi_cnt++;
        if (hi_cnt >= 3) m_ack = 1'b1;
      end else begin
        hi_cnt = 0; lo_cnt++;
        if (lo_cnt >= 2) m_ack = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    p_send = 1'b0; p_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p_send = 1'b0;
      end else begin
        if (send && !p_send) begin
          rise_t.push_back(cyc);
          if (exp_q.size() == 0) check("send_unexpected", 32'(send), 32'd0);
          else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
        if (send && p_send && data_out != p_data) n_unstable++;
        if (send) n_send_hi++;
        if (done) n_done++;
        if (err) n_err++;
        if (count > 3'd4) n_over++;
        p_send = send;
        p_data = data_out;
      end
    end
  end

  // driver tasks (called at a negedge)
  task automatic push_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        exp_q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (o_state == IDLE && count == 3'd0 && !send) return;
      @(negedge clk);
    end
    check("wait_idle_timeout", 32'(o_state), 32'(IDLE));
  endtask

  task automatic single_word(input logic [7:0] d);
    push_word(d);
    @(negedge clk);
    check("sw_send_e1", 32'(send), 32'd1);
    check("sw_data_e1", 32'(data_out), 32'(d));
    check("sw_state_e1", 32'(o_state), 32'(REQ));
    @(negedge clk);
    @(negedge clk);
    check("sw_send_e3", 32'(send), 32'd1);
    check("sw_done_e3", 32'(done), 32'd0);
    @(negedge clk);
    check("sw_done_e4", 32'(done), 32'd1);
    check("sw_send_e4", 32'(send), 32'd0);
    @(negedge clk);
    check("sw_done_e5", 32'(done), 32'd0);
    check("sw_state_e5", 32'(o_state), 32'(REL));
    @(negedge clk);
    check("sw_state_e6", 32'(o_state), 32'(IDLE));
    check("sw_data_kept", 32'(data_out), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, n0;
    logic [7:0] rnd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ack_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      check("reset_idle", {send, count, in_ready, done, err}, 32'b0_000_1_0_0);
      @(negedge clk);
    end

    // single word with the peripheral model
    ack_mode = 1'b1;
    single_word(8'hA5);

    // burst of four back-to-back words
    d0 = n_done; rise_t.delete();
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    check("burst_full_ready", 32'(in_ready), 32'd0);
    check("burst_full_count", 32'(count), 32'd4);
    wait_idle(60);
    check("burst_rises", 32'(rise_t.size()), 32'd4);
    for (int i = 1; i < rise_t.size(); i++)
      check("burst_spacing", 32'(rise_t[i] - rise_t[i-1]), 32'd5);
    check("burst_done", 32'(n_done - d0), 32'd4);
    check("burst_count_end", 32'(count), 32'd0);

    // full FIFO with producer holding a word until a pop frees a slot
    ack_mode = 1'b0; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom_range(255, 0));
      push_word(rnd);
    end
    check("full_count", 32'(count), 32'd4);
    in_data = 8'h3C; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_hold_ready", 32'(in_ready), 32'd0);
    check("full_hold_count", 32'(count), 32'd4);
    ack_mode = 1'b1;
    push_word(8'h3C);
    push_word(8'hC3);
    wait_idle(80);
    check("full_no_over", 32'(n_over), 32'd0);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    check("full_done", 32'(n_done - d0), 32'd6);
    check("full_no_err", 32'(n_err - e0), 32'd0);

    // timeout with ack tied low
    ack_mode = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_done; e0 = n_err; n0 = n_send_hi;
    push_word(8'h5A);
    for (int t = 0; t < 40 && n_err == e0; t++) @(negedge clk);
    check("tmo_send_cycles", 32'(n_send_hi - n0), 32'd16);
    repeat (3) @(negedge clk);
    check("tmo_err_once", 32'(n_err - e0), 32'd1);
    check("tmo_no_done", 32'(n_done - d0), 32'd0);
    check("tmo_count", 32'(count), 32'd0);
    check("tmo_send_low", 32'(send), 32'd0);
    check("tmo_data_kept", 32'(data_out), 32'h5A);

    // reset in the middle of a handshake
    wait_idle(20);
    d0 = n_done; e0 = n_err;
    push_word(8'h21);
    push_word(8'h22);
    push_word(8'h23);
    check("rst_mid_count", 32'(count), 32'd3);
    check("rst_mid_state", 32'(o_state), 32'(REQ));
    #2 rst = 1'b1;
    #1;
    check("rst_async_send", 32'(send), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ack_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(n_done - d0), 32'd0);
    check("rst_no_err", 32'(n_err - e0), 32'd0);
    check("rst_idle", 32'(o_state), 32'(IDLE));
    single_word(8'hA5);

    check("data_stable", 32'(n_unstable), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
